// File: rtl/display_scanout.sv
// Raster scan-out controller: generates sync/DE timing, streams read requests to
// the frame buffer and realigns the buffer's registered pixel data with the syncs.
module display_scanout #(
   parameter int unsigned H_ACTIVE  = 100,
   parameter int unsigned V_ACTIVE  = 100,
   parameter int unsigned H_FP      = 4,
   parameter int unsigned H_SYNC    = 8,
   parameter int unsigned H_BP      = 4,
   parameter int unsigned V_FP      = 2,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 2,
   parameter logic [23:0] BLANK_RGB = 24'h000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        frame_ready,
   output logic        rd_en,
   output logic [19:0] rd_addr,
   input  logic [7:0]  r_in,
   input  logic [7:0]  g_in,
   input  logic [7:0]  b_in,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [7:0]  r_out,
   output logic [7:0]  g_out,
   output logic [7:0]  b_out,
   output logic        frame_done,
   output logic        underrun
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_LAST_PX = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] H_SYNC_S  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_E  = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_END     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_LAST_PX = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] V_SYNC_S  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_E  = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_END     = VW'(V_TOTAL - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          r_state, w_state_next;
   logic [HW-1:0]   r_h_cnt;
   logic [VW-1:0]   r_v_cnt;
   logic            r_frame_valid;
   logic            r_s1_hs, r_s1_vs, r_s1_de, r_s1_valid;
   logic            r_s2_hs, r_s2_vs, r_s2_de, r_s2_valid;

   logic            w_frame_start, w_valid, w_active, w_run, w_req, w_hs, w_vs;

   assign w_frame_start = (r_state == RUN) && (r_h_cnt == '0) && (r_v_cnt == '0);
   // frame_ready only matters on the frame-start cycle; afterwards the latched copy rules
   assign w_valid  = w_frame_start ? frame_ready : r_frame_valid;
   assign w_active = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
   assign w_run    = (r_state == RUN) && (w_state_next == RUN);
   assign w_req    = w_run && w_active && w_valid;
   assign w_hs     = !((r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E));
   assign w_vs     = !((r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E));

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (enable) w_state_next = RUN;
         RUN:     if (w_frame_start && !enable) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || !w_run) begin
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_frame_valid <= 1'b0;
         rd_en         <= 1'b0;
         rd_addr       <= '0;
         frame_done    <= 1'b0;
         underrun      <= 1'b0;
         r_s1_hs       <= 1'b1;
         r_s1_vs       <= 1'b1;
         r_s1_de       <= 1'b0;
         r_s1_valid    <= 1'b0;
         r_s2_hs       <= 1'b1;
         r_s2_vs       <= 1'b1;
         r_s2_de       <= 1'b0;
         r_s2_valid    <= 1'b0;
         hsync         <= 1'b1;
         vsync         <= 1'b1;
         de            <= 1'b0;
         r_out         <= '0;
         g_out         <= '0;
         b_out         <= '0;
      end else begin
         if (r_h_cnt == H_END) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_END) ? '0 : r_v_cnt + 1'b1;
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
         if (w_frame_start) r_frame_valid <= frame_ready;

         rd_en      <= w_req;
         if (w_frame_start)  rd_addr <= '0;
         else if (w_req)     rd_addr <= rd_addr + 20'd1;
         frame_done <= w_req && (r_h_cnt == H_LAST_PX) && (r_v_cnt == V_LAST_PX);
         underrun   <= w_frame_start && !frame_ready;

         // two delay stages so syncs/DE line up with the buffer's registered data
         r_s1_hs    <= w_hs;
         r_s1_vs    <= w_vs;
         r_s1_de    <= w_active;
         r_s1_valid <= w_valid;
         r_s2_hs    <= r_s1_hs;
         r_s2_vs    <= r_s1_vs;
         r_s2_de    <= r_s1_de;
         r_s2_valid <= r_s1_valid;

         hsync <= r_s2_hs;
         vsync <= r_s2_vs;
         de    <= r_s2_de;
         if (!r_s2_de) begin
            r_out <= '0;
            g_out <= '0;
            b_out <= '0;
         end else if (r_s2_valid) begin
            r_out <= r_in;
            g_out <= g_in;
            b_out <= b_in;
         end else begin
            r_out <= BLANK_RGB[7:0];
            g_out <= BLANK_RGB[15:8];
            b_out <= BLANK_RGB[23:16];
         end
      end
   end

endmodule

// File: tb/tb_display_scanout.sv
// Bench for display_scanout: startup/reset vector table, three-frame randomized
// run against a position-based raster model, and a mid-frame reset sequence.
module tb_display_scanout;

   localparam int HA = 100, VA = 100;
   localparam int HT = 100 + 4 + 8 + 4;
   localparam int VT = 100 + 2 + 2 + 2;
   localparam int FT = HT * VT;
   localparam int STOP = 3 * FT;
   localparam logic [23:0] BLANK = 24'h3C5A7E;
   localparam logic [49:0] RST_B = {1'b0, 20'd0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0, 1'b0};

   logic clk = 1'b0;
   logic reset, enable, frame_ready;
   logic rd_en, hsync, vsync, de, frame_done, underrun;
   logic [19:0] rd_addr;
   logic [7:0] r_in, g_in, b_in, r_out, g_out, b_out;

   int checks = 0;
   int errors = 0;
   logic rdy_plan [3];

   display_scanout #(
      .H_ACTIVE(100), .V_ACTIVE(100), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_FP(2), .V_SYNC(2), .V_BP(2), .BLANK_RGB(BLANK)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .frame_ready(frame_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .hsync(hsync), .vsync(vsync), .de(de), .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .frame_done(frame_done), .underrun(underrun)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pix(input logic [19:0] a);
      return {a[7:0] + 8'h3C, a[15:8] ^ 8'hA5, a[7:0]};
   endfunction

   // Frame buffer: one-cycle registered read; garbage when not read
   always @(posedge clk) begin
      if (rd_en) {b_in, g_in, r_in} <= pix(rd_addr);
      else       {b_in, g_in, r_in} <= 24'($urandom);
   end

   function automatic logic [49:0] actual();
      return {rd_en, rd_addr, hsync, vsync, de, b_out, g_out, r_out, frame_done, underrun};
   endfunction

   // m = number of clock edges since the edge that entered RUN
   function automatic logic [49:0] model(input int m);
      int p, q, h, v, f, last;
      logic val, en, dn, un, hs, vs, dd;
      logic [19:0] a;
      logic [23:0] rgb;
      en = 0; a = '0; dn = 0; un = 0; hs = 1; vs = 1; dd = 0; rgb = '0;
      if (m >= 1 && m - 1 < STOP) begin
         p = m - 1; f = p / FT; q = p % FT; h = q % HT; v = q / HT;
         val = rdy_plan[f];
         if (val) begin
            en   = (h < HA) && (v < VA);
            last = (v >= VA) ? HA * VA - 1 : ((h >= HA) ? v * HA + HA - 1 : v * HA + h);
            a    = 20'(last);
            dn   = en && (v * HA + h == HA * VA - 1);
         end
         un = (q == 0) && !val;
         if (m >= 3) begin
            p = m - 3; f = p / FT; q = p % FT; h = q % HT; v = q / HT;
            hs = !(h >= 104 && h < 112);
            vs = !(v >= 102 && v < 104);
            dd = (h < HA) && (v < VA);
            if (dd) rgb = rdy_plan[f] ? pix(20'(v * HA + h)) : BLANK;
         end
      end
      return {en, a, hs, vs, dd, rgb, dn, un};
   endfunction

   task automatic check(input string name, input logic [49:0] act, input logic [49:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic rst, en, rdy;
      logic [49:0] exp;
   } vec_t;

   initial begin
      vec_t tbl [8];
      int p, q;
      logic found;

      tbl[0] = '{1'b1, 1'b0, 1'b1, RST_B};
      tbl[1] = '{1'b0, 1'b0, 1'b1, RST_B};
      tbl[2] = '{1'b0, 1'b1, 1'b1, RST_B};
      tbl[3] = '{1'b0, 1'b1, 1'b1, {1'b1, 20'd0, 3'b110, 24'd0, 2'b00}};
      tbl[4] = '{1'b0, 1'b1, 1'b0, {1'b1, 20'd1, 3'b110, 24'd0, 2'b00}};
      tbl[5] = '{1'b0, 1'b1, 1'b0, {1'b1, 20'd2, 3'b111, pix(20'd0), 2'b00}};
      tbl[6] = '{1'b1, 1'b1, 1'b1, RST_B};
      tbl[7] = '{1'b0, 1'b0, 1'b1, RST_B};

      reset = 1'b1; enable = 1'b0; frame_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         reset = tbl[i].rst; enable = tbl[i].en; frame_ready = tbl[i].rdy;
         step();
         check($sformatf("vec%0d", i), actual(), tbl[i].exp);
      end

      // Frames: valid, underrun, valid (enable dropped at line 50), then IDLE
      rdy_plan[0] = 1'b1; rdy_plan[1] = 1'b0; rdy_plan[2] = 1'b1;
      enable = 1'b1; frame_ready = 1'b1;
      step();
      check("entry", actual(), model(0));
      for (int m = 1; m <= STOP + 10; m++) begin
         p = m - 1; q = p % FT;
         if (p >= STOP) begin
            enable = 1'b0; frame_ready = 1'($urandom);
         end else if (q == 0) begin
            enable = 1'b1; frame_ready = rdy_plan[p / FT];
         end else begin
            enable = (p >= 2 * FT + 50 * HT) ? 1'b0 : 1'($urandom);
            frame_ready = 1'($urandom);
         end
         step();
         check($sformatf("cyc%0d", m), actual(), model(m));
         if (errors > 20) break;
      end

      // Reset mid-frame at address 4321, then restart from 0
      enable = 1'b1; frame_ready = 1'b1;
      step();
      found = 1'b0;
      for (int k = 0; k < 6000; k++) begin
         step();
         if (rd_en === 1'b1 && rd_addr === 20'd4321) begin
            found = 1'b1;
            break;
         end
      end
      check("reach4321", {49'd0, found}, 50'd1);
      reset = 1'b1;
      step();
      check("rst_mid", actual(), RST_B);
      reset = 1'b0;
      step();
      check("rst_entry", actual(), RST_B);
      step();
      check("restart", {30'd0, rd_en, rd_addr}, {30'd0, 1'b1, 20'd0});
      step();
      check("restart2", {30'd0, rd_en, rd_addr}, {30'd0, 1'b1, 20'd1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
